lsu_wb_master: RTL and testbench
================================

# lsu_wb_master

Load/store unit bus master between the core's MEM stage and the byte-addressed data memory. It accepts one load/store request at a time and checks alignment. It then runs a single Wishbone classic cycle with funct3 passed through, because the memory does sign/zero extension and byte lanes itself. It returns the read data or an error to the pipeline and stalls the pipeline while the bus cycle is in flight.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 11, byte address width; 11 bits covers 2 KB.
- TIMEOUT_CYCLES, 16, number of BUS cycles without ack before the error response; minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  MEM stage has a load/store; held with all req_* stable until rsp_valid_o.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RISC-V funct3 of the access.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  store data, right-aligned.
- stall_o  out  1  hold the pipeline.
- rsp_valid_o  out  1  one-cycle pulse; the access has completed.
- rsp_rdata_o  out  DATA_WIDTH  load result, already extended; 0 for stores and errors.
- rsp_err_o  out  1  misaligned, illegal funct3 or timeout; qualified by rsp_valid_o.
- wb_cyc_o, wb_stb_o  out  1 each  Wishbone cycle/strobe, always driven together.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  ADDR_WIDTH  byte address.
- wb_dat_o  out  DATA_WIDTH  write data.
- wb_funct3_o  out  3  access size/sign to the slave.
- wb_dat_i  in  DATA_WIDTH  read data; valid combinationally while cyc&stb&!we.
- wb_ack_i  in  1  slave acknowledge.

## Operation
- FSM states: IDLE, BUS, RESP; encoding is 2 bits.
- IDLE, when req_valid_i is high:
  - Run the alignment check.
  - Legal access: latch addr, wdata, we and funct3, clear the timeout counter, and go to BUS.
  - Illegal access: no bus cycle; set err=1 and go to RESP.
- Legal accesses:
  - funct3 000/100 (byte): any address.
  - funct3 001/101 (half): addr[0]=0.
  - funct3 010 (word): addr[1:0]=00.
  - Loads accept funct3 000, 001, 010, 100, 101; stores accept 000, 001, 010. Everything else is illegal.
- BUS:
  - wb_cyc_o=wb_stb_o=1, with the latched values on wb_adr_o, wb_dat_o, wb_we_o and wb_funct3_o.
  - On wb_ack_i: capture wb_dat_i into the rdata register for loads (0 for stores) and go to RESP.
  - cyc/stb drop on that same edge. This is mandatory: the slave re-acks every cycle that cyc&stb stay high, and a second write must never be issued.
  - The timeout counter increments each BUS cycle. When it reaches TIMEOUT_CYCLES-1 with no ack, set err=1, rdata=0 and go to RESP.
- RESP: rsp_valid_o=1 for exactly one cycle, then go to IDLE. rsp_rdata_o/rsp_err_o hold their values until the next RESP.
- stall_o = (state==BUS) | (state==IDLE & req_valid_i). It is low in RESP so the pipeline advances on the response edge.
- wb_ack_i outside BUS is ignored.

## Timing
- Reset values: state IDLE; wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_adr_o, wb_dat_o, wb_funct3_o = 0; rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0; stall_o follows its equation.
- Reset asserted mid-BUS: cyc/stb fall asynchronously, the transaction is abandoned and no response is issued.
- Legal access to a slave that registers ack: request seen in cycle 0 (IDLE); cyc/stb high in cycles 1–2; ack seen in cycle 2; rsp_valid_o in cycle 3. Latency is 3 cycles.
- Illegal access: rsp_valid_o with err in cycle 1; bus untouched.
- Timeout: rsp_valid_o with err in cycle TIMEOUT_CYCLES+1.
- Back-to-back: a new request may be accepted in the IDLE cycle right after RESP. Minimum spacing is 4 cycles per access.

## Structure
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the FSM state encoding;
  - default DATA_WIDTH and ADDR_WIDTH.
- Sub-module lsu_align_check: combinational check of (funct3, we, addr[1:0]) producing legal. It is instantiated once in IDLE decode.

## Test plan
- Store word 0xDEADBEEF to 0x010, then lw from 0x010: exactly one wb write cycle (one cycle with ack while we=1); load returns 0xDEADBEEF with rsp_valid_o in cycle 3; err=0.
- sb 0x80 at 0x021, then lb 0x021 -> 0xFFFFFF80; lbu 0x021 -> 0x00000080; wb_funct3_o matches each request.
- lh at 0x003 and sw at 0x002 -> rsp_err_o=1 in cycle 1; wb_cyc_o never rises; memory unchanged.
- Slave ack tied low, TIMEOUT_CYCLES=16 -> err response in cycle 17; cyc drops; next request proceeds normally.
- rst pulsed during BUS of a sw -> cyc/stb low immediately; no rsp_valid_o; state IDLE; memory word unchanged.
- Four back-to-back loads held valid -> stall_o high except in RESP cycles; exactly four rsp_valid_o pulses, 4 cycles apart.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// lsu_pkg: shared funct3 codes, FSM encoding and default widths for the LSU Wishbone master.
package lsu_pkg;

  localparam int LSU_DATA_WIDTH = 32;
  localparam int LSU_ADDR_WIDTH = 11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_wb_master_if.sv
`default_nettype none
// lsu_wb_master_if: pipeline request/response and Wishbone classic signals, named from the LSU's view.
interface lsu_wb_master_if
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
);
  logic                  req_valid_i;
  logic                  req_we_i;
  logic [2:0]            req_funct3_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  stall_o;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [2:0]            wb_funct3_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;

  modport master (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, wb_dat_i, wb_ack_i,
    output stall_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_funct3_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, wb_dat_i, wb_ack_i,
    input  stall_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_funct3_o
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align_check.sv
`default_nettype none
// lsu_align_check: decides whether a (funct3, we, addr[1:0]) access may go to the bus.
module lsu_align_check
  import lsu_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       we_i,
  input  logic [1:0] addr_lo_i,
  output logic       legal_o
);

  // Unsigned loads have no store counterpart, so BU/HU are load-only.
  always_comb begin
    legal_o = 1'b0;
    case (funct3_i)
      F3_B:    legal_o = 1'b1;
      F3_BU:   legal_o = !we_i;
      F3_H:    legal_o = !addr_lo_i[0];
      F3_HU:   legal_o = !we_i && !addr_lo_i[0];
      F3_W:    legal_o = (addr_lo_i == 2'b00);
      default: legal_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_wb_master.sv
`default_nettype none
// lsu_wb_master: one-at-a-time load/store unit issuing a single Wishbone classic cycle per access.
module lsu_wb_master
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = LSU_DATA_WIDTH,
  parameter int ADDR_WIDTH     = LSU_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  lsu_wb_master_if.master bus
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e            state_q;
  logic                  cyc_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [2:0]            funct3_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  legal;

  lsu_align_check u_align (
    .funct3_i  (bus.req_funct3_i),
    .we_i      (bus.req_we_i),
    .addr_lo_i (bus.req_addr_i[1:0]),
    .legal_o   (legal)
  );

  assign cnt_d = cnt_q + 1'b1;

  // cyc_q clears on the ack edge: the slave re-acks while cyc/stb stay high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      funct3_q    <= 3'b000;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            if (legal) begin
              adr_q    <= bus.req_addr_i;
              dat_q    <= bus.req_wdata_i;
              we_q     <= bus.req_we_i;
              funct3_q <= bus.req_funct3_i;
              cnt_q    <= '0;
              cyc_q    <= 1'b1;
              state_q  <= ST_BUS;
            end else begin
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_BUS: begin
          if (bus.wb_ack_i) begin
            cyc_q       <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : bus.wb_dat_i;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            cyc_q       <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall_o     = (state_q == ST_BUS) || ((state_q == ST_IDLE) && bus.req_valid_i);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = cyc_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_adr_o    = adr_q;
  assign bus.wb_dat_o    = dat_q;
  assign bus.wb_funct3_o = funct3_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_wb_master.sv
`default_nettype none
// tb_lsu_wb_master: byte-memory Wishbone slave plus an access-level reference model of the LSU.
module tb_lsu_wb_master;
  import lsu_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_wb_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) bus ();

  lsu_wb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- Wishbone slave: registered ack, re-acks while cyc&stb stay high
  logic [7:0] mem [0:2047];
  logic       ack_q = 1'b0;
  bit         ack_en = 1'b1;
  bit         mem_init = 1'b1;
  int         wr_count = 0;
  int         n_rsp = 0;
  logic [31:0] rd_comb;

  always @(posedge clk) begin
    ack_q <= bus.wb_cyc_o & bus.wb_stb_o & ack_en;
    if (mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_byte(i);
    end else if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_we_o && ack_q) begin
      wr_count <= wr_count + 1;
      mem[bus.wb_adr_o] <= bus.wb_dat_o[7:0];
      if (bus.wb_funct3_o[1:0] != 2'b00) mem[bus.wb_adr_o + 11'd1] <= bus.wb_dat_o[15:8];
      if (bus.wb_funct3_o[1:0] == 2'b10) begin
        mem[bus.wb_adr_o + 11'd2] <= bus.wb_dat_o[23:16];
        mem[bus.wb_adr_o + 11'd3] <= bus.wb_dat_o[31:24];
      end
    end
  end

  always @(posedge clk) if (bus.rsp_valid_o) n_rsp <= n_rsp + 1;

  always_comb begin
    rd_comb = 32'h0;
    if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_we_o)
      rd_comb = load_ext(bus.wb_funct3_o, mem[bus.wb_adr_o], mem[bus.wb_adr_o + 11'd1],
                         mem[bus.wb_adr_o + 11'd2], mem[bus.wb_adr_o + 11'd3]);
  end
  assign bus.wb_dat_i = rd_comb;
  assign bus.wb_ack_i = ack_q;

  // ---------------- reference model
  logic [7:0] ref_mem [0:2047];

  function automatic bit model_legal(input logic we, input logic [2:0] f3, input logic [10:0] a);
    bit size_ok;
    bit kind_ok;
    size_ok = (f3 == 3'd0 || f3 == 3'd4) ||
              ((f3 == 3'd1 || f3 == 3'd5) && a[0] == 1'b0) ||
              (f3 == 3'd2 && a[1:0] == 2'b00);
    kind_ok = we ? (f3 <= 3'd2) : 1'b1;
    return size_ok && kind_ok;
  endfunction

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [10:0] a,
                         input logic [31:0] wd);
    bit legal, err_exp, got, seen;
    int lat_exp, k, wr0, nbytes;
    logic [31:0] rd_exp;
    legal   = model_legal(we, f3, a);
    err_exp = !legal || !ack_en;
    lat_exp = !legal ? 1 : (ack_en ? 3 : TO + 1);
    rd_exp  = (legal && !we && ack_en) ?
              load_ext(f3, ref_mem[a], ref_mem[a + 11'd1], ref_mem[a + 11'd2], ref_mem[a + 11'd3]) : 32'h0;
    wr0 = wr_count;
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = a;
    bus.req_wdata_i  = wd;
    k = 0; got = 0; seen = 0;
    while (!got && k <= 40) begin
      @(negedge clk);
      if (bus.rsp_valid_o) begin
        got = 1;
        chk("cyc_in_resp", 32'(bus.wb_cyc_o), 32'h0);
        chk("stall_in_resp", 32'(bus.stall_o), 32'h0);
      end else begin
        chk("stall_busy", 32'(bus.stall_o), 32'h1);
        if (bus.wb_cyc_o && !seen) begin
          seen = 1;
          chk("stb", 32'(bus.wb_stb_o), 32'h1);
          chk("wb_adr", 32'(bus.wb_adr_o), 32'(a));
          chk("wb_we", 32'(bus.wb_we_o), 32'(we));
          chk("wb_funct3", 32'(bus.wb_funct3_o), 32'(f3));
          chk("wb_dat", bus.wb_dat_o, wd);
        end
        k++;
      end
    end
    chk("rsp_seen", 32'(got), 32'h1);
    chk("latency", 32'(k), 32'(lat_exp));
    chk("rsp_err", 32'(bus.rsp_err_o), 32'(err_exp));
    chk("rsp_rdata", bus.rsp_rdata_o, rd_exp);
    chk("cyc_seen", 32'(seen), 32'(legal));
    chk("wr_count", 32'(wr_count - wr0), (legal && we && ack_en) ? 32'h1 : 32'h0);
    if (legal && we && ack_en) begin
      nbytes = (f3 == 3'd0) ? 1 : ((f3 == 3'd1) ? 2 : 4);
      for (int b = 0; b < nbytes; b++) ref_mem[a + 11'(b)] = wd[8*b +: 8];
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    chk("rsp_pulse_end", 32'(bus.rsp_valid_o), 32'h0);
    chk("rsp_err_hold", 32'(bus.rsp_err_o), 32'(err_exp));
    chk("rsp_rdata_hold", bus.rsp_rdata_o, rd_exp);
  endtask

  task automatic reset_abort(input logic [10:0] a, input logic [31:0] wd);
    int wr0, r0;
    wr0 = wr_count;
    r0  = n_rsp;
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_funct3_i = F3_W;
    bus.req_addr_i   = a;
    bus.req_wdata_i  = wd;
    @(negedge clk);
    @(negedge clk);
    chk("abort_cyc_before", 32'(bus.wb_cyc_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_cyc_async", 32'(bus.wb_cyc_o), 32'h0);
    chk("abort_stb_async", 32'(bus.wb_stb_o), 32'h0);
    bus.req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_no_rsp", 32'(n_rsp - r0), 32'h0);
    chk("abort_no_write", 32'(wr_count - wr0), 32'h0);
    chk("abort_idle_stall", 32'(bus.stall_o), 32'h0);
    chk("abort_cyc_after", 32'(bus.wb_cyc_o), 32'h0);
  endtask

  initial begin
    int r0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_byte(i);
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'b000;
    bus.req_addr_i   = 11'h0;
    bus.req_wdata_i  = 32'h0;
    repeat (2) @(posedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    chk("rst_cyc", 32'(bus.wb_cyc_o), 32'h0);
    chk("rst_stb", 32'(bus.wb_stb_o), 32'h0);
    chk("rst_we", 32'(bus.wb_we_o), 32'h0);
    chk("rst_adr", 32'(bus.wb_adr_o), 32'h0);
    chk("rst_dat", bus.wb_dat_o, 32'h0);
    chk("rst_funct3", 32'(bus.wb_funct3_o), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err_o), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, 32'h0);
    chk("rst_stall", 32'(bus.stall_o), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_req(1'b1, F3_W,  11'h010, 32'hDEADBEEF);
    run_req(1'b0, F3_W,  11'h010, 32'h0);
    run_req(1'b1, F3_B,  11'h021, 32'h00000080);
    run_req(1'b0, F3_B,  11'h021, 32'h0);
    run_req(1'b0, F3_BU, 11'h021, 32'h0);
    run_req(1'b0, F3_H,  11'h003, 32'h0);
    run_req(1'b1, F3_W,  11'h002, 32'h12345678);
    run_req(1'b0, F3_W,  11'h000, 32'h0);
    run_req(1'b0, F3_W,  11'h004, 32'h0);

    ack_en = 1'b0;
    run_req(1'b0, F3_W, 11'h010, 32'h0);
    ack_en = 1'b1;
    run_req(1'b0, F3_W, 11'h010, 32'h0);

    reset_abort(11'h040, 32'hCAFEF00D);
    run_req(1'b0, F3_W, 11'h040, 32'h0);

    r0 = n_rsp;
    for (int i = 0; i < 4; i++) run_req(1'b0, F3_W, 11'(4 * i), 32'h0);
    chk("b2b_pulses", 32'(n_rsp - r0), 32'h4);

    for (int i = 0; i < 80; i++) begin
      logic [10:0] a;
      logic [2:0]  f3;
      logic        we;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 11'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = (f3[1:0] == 2'b10) ? {a[10:2], 2'b00} : {a[10:1], 1'b0};
      run_req(we, f3, a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
